fft_input_framer: RTL and testbench
===================================

// Module: fft_input_framer
// PURPOSE
//   Serial-to-parallel ping-pong framer at the front of the 32-point FFT.
//   Accepts one complex sample per beat over a valid/ready handshake.
//   Writes each frame into one of two register banks, in bit-reversed order.
//   Presents a complete 32-sample frame to stage 1 with a valid/ready handshake.
//   The stage-1 load is triggered by frame_valid & frame_ready; the controller drives frame_ready.
// PARAMETERS
//   DATA_W       16  width of each real/imag component (two's complement)
//   N_POINTS     32  samples per frame (power of 2)
//   LOG2N        5   log2(N_POINTS); sample index width
//   BIT_REVERSE  1   1: sample k stored at slot bitrev(k); 0: stored at slot k
// PORTS
//   clk_100      in   1                  single clock; all logic on posedge
//   reset_all    in   1                  synchronous, active-high reset
//   in_valid     in   1                  input sample present
//   in_ready     out  1                  framer can accept a sample
//   in_re        in   DATA_W             sample real part
//   in_im        in   DATA_W             sample imag part
//   in_last      in   1                  marks the last sample of a frame
//   frame_valid  out  1                  a full frame is on frame_re/frame_im
//   frame_ready  in   1                  stage 1 consumes the frame
//   frame_re     out  N_POINTS*DATA_W    slot s is bits [s*DATA_W +: DATA_W]
//   frame_im     out  N_POINTS*DATA_W    same layout as frame_re
//   frame_err    out  1                  1-cycle pulse: in_last misaligned
//   frame_cnt    out  8                  frames consumed, wraps 255->0
// BEHAVIOUR
//   Reset (sync, reset_all=1 at posedge) clears all state:
//     idx=0; wr_bank=0; rd_bank=0; full[1:0]=0.
//     Both banks are zeroed, so frame_re=0 and frame_im=0.
//     Outputs: frame_valid=0, frame_err=0, frame_cnt=0, in_ready=1.
//   Reset mid-frame discards any partial or full frame. No frame_valid follows.
//   Write side, per-bank FSM over wr_bank:
//     W_FILL: in_ready = !full[wr_bank].
//     An accepted beat (in_valid & in_ready) writes slot bitrev(idx) (or idx), then idx++.
//     If idx==N-1 on an accepted beat:
//       set full[wr_bank]; toggle wr_bank; idx=0.
//       If in_last=0, pulse frame_err; the frame is still kept.
//     If in_last=1 with idx<N-1:
//       pulse frame_err; idx=0; the bank is not marked full (partial frame dropped).
//     W_STALL (full[wr_bank]=1): in_ready=0; no writes.
//       Resume in the cycle after that bank is consumed.
//   Read side:
//     frame_valid = full[rd_bank]. frame_re/frame_im are muxed from rd_bank.
//     Handshake frame_valid & frame_ready: clear full[rd_bank]; toggle rd_bank; frame_cnt++.
//     Frame data must be held stable while frame_valid=1 and frame_ready=0.
//     frame_ready while frame_valid=0 is ignored.
//   Latency: last beat accepted at edge T -> frame_valid=1 after edge T (next cycle).
//     This assumes rd_bank points at that bank.
//   Throughput: one sample per clock sustained, provided stage 1 consumes within N cycles.
//   Simultaneous events:
//     Completing bank A and consuming bank B in one cycle: both take effect.
//     in_ready for the just-freed bank rises the next cycle (no combinational ready path).
//   Arithmetic: samples are stored unmodified; no scaling or rounding.
// STRUCTURE
//   fft_pkg (shared): N_POINTS, LOG2N, DATA_W constants; function bitrev(LOG2N).
//     The same bitrev function is used by the output reorder stage.
//   Sub-module fft_frame_bank, instantiated x2:
//     N_POINTS x (2*DATA_W) registers with sync clear, one write port (we, addr, re, im).
//     Flattened full-frame read outputs.
//   Top level holds idx, wr_bank/rd_bank, full flags, frame_cnt, frame_err, output mux.
// TESTING
//   1. Reset, then send samples k=0..31 (re=k, im=-k, in_last at k=31), frame_ready=0.
//      -> frame_valid=1 one cycle after the last beat.
//      -> Slot 1 holds k=16; slot 31 holds k=31; slot 0 holds k=0.
//   2. Stream 3 frames back-to-back with frame_ready=1 constantly.
//      -> in_ready never drops; 3 frame_valid handshakes; frame_cnt=3; no frame_err.
//   3. Fill both banks with frame_ready=0.
//      -> in_ready=0 after the 64th beat; frame data stable.
//      -> Pulse frame_ready once: in_ready=1 the next cycle; frame_cnt=1.
//   4. Assert in_last at k=9.
//      -> frame_err one cycle; no frame_valid; the next 32 beats form a correct frame.
//   5. Assert reset_all at k=20 of a frame.
//      -> All outputs return to reset values; a following full frame is correct.
//   6. Complete 256 frames.
//      -> frame_cnt wraps to 0.
//      -> With BIT_REVERSE=0, slot s == sample s.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 32-point FFT datapath.
package fft_pkg;

  localparam int FFT_DATA_W   = 16;
  localparam int FFT_N_POINTS = 32;
  localparam int FFT_LOG2N    = 5;

  // Write-side state: filling the current bank, or waiting for it to drain
  typedef enum logic {
    W_FILL  = 1'b0,
    W_STALL = 1'b1
  } wr_state_e;

  // Bit-reversed sample index; shared with the output reorder stage
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] k);
    logic [FFT_LOG2N-1:0] r;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      r[b] = k[FFT_LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of complex sample storage: single write port, whole-frame read.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DATA_W   = FFT_DATA_W,
  parameter int N_POINTS = FFT_N_POINTS,
  parameter int LOG2N    = FFT_LOG2N
) (
  input  logic                       clk_i,
  input  logic                       clr_i,
  input  logic                       we_i,
  input  logic [LOG2N-1:0]           addr_i,
  input  logic signed [DATA_W-1:0]   re_i,
  input  logic signed [DATA_W-1:0]   im_i,
  output logic [N_POINTS*DATA_W-1:0] frame_re_o,
  output logic [N_POINTS*DATA_W-1:0] frame_im_o
);

  logic signed [DATA_W-1:0] re_q [N_POINTS];
  logic signed [DATA_W-1:0] im_q [N_POINTS];

  // Slot storage: cleared as a whole, written one slot per beat
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int s = 0; s < N_POINTS; s++) begin
        re_q[s] <= '0;
        im_q[s] <= '0;
      end
    end else if (we_i) begin
      re_q[addr_i] <= re_i;
      im_q[addr_i] <= im_i;
    end
  end

  // Flatten slots so slot s sits at bits [s*DATA_W +: DATA_W]
  always_comb begin
    frame_re_o = '0;
    frame_im_o = '0;
    for (int s = 0; s < N_POINTS; s++) begin
      frame_re_o[s*DATA_W +: DATA_W] = re_q[s];
      frame_im_o[s*DATA_W +: DATA_W] = im_q[s];
    end
  end

endmodule

// File: rtl/fft_input_framer.sv
// Serial-to-parallel ping-pong framer feeding FFT stage 1.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int DATA_W      = FFT_DATA_W,
  parameter int N_POINTS    = FFT_N_POINTS,
  parameter int LOG2N       = FFT_LOG2N,
  parameter int BIT_REVERSE = 1
) (
  input  logic                       clk_100,
  input  logic                       reset_all,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_re,
  input  logic signed [DATA_W-1:0]   in_im,
  input  logic                       in_last,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [N_POINTS*DATA_W-1:0] frame_re,
  output logic [N_POINTS*DATA_W-1:0] frame_im,
  output logic                       frame_err,
  output logic [7:0]                 frame_cnt
);

  logic [LOG2N-1:0] idx_q, idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  wr_state_e        wr_state_q, wr_state_d;

  logic             accept, consume, last_slot;
  logic [LOG2N-1:0] wr_addr;
  logic [N_POINTS*DATA_W-1:0] bank_re [2];
  logic [N_POINTS*DATA_W-1:0] bank_im [2];

  assign in_ready    = (wr_state_q == W_FILL);
  assign frame_valid = full_q[rd_bank_q];
  assign frame_err   = err_q;
  assign frame_cnt   = cnt_q;

  assign accept    = in_valid & in_ready;
  assign consume   = frame_valid & frame_ready;
  assign last_slot = (idx_q == LOG2N'(N_POINTS-1));
  assign wr_addr   = (BIT_REVERSE != 0) ? bitrev(idx_q) : idx_q;

  fft_frame_bank #(.DATA_W(DATA_W), .N_POINTS(N_POINTS), .LOG2N(LOG2N)) u_bank0 (
    .clk_i      (clk_100),
    .clr_i      (reset_all),
    .we_i       (accept & ~wr_bank_q),
    .addr_i     (wr_addr),
    .re_i       (in_re),
    .im_i       (in_im),
    .frame_re_o (bank_re[0]),
    .frame_im_o (bank_im[0])
  );

  fft_frame_bank #(.DATA_W(DATA_W), .N_POINTS(N_POINTS), .LOG2N(LOG2N)) u_bank1 (
    .clk_i      (clk_100),
    .clr_i      (reset_all),
    .we_i       (accept & wr_bank_q),
    .addr_i     (wr_addr),
    .re_i       (in_re),
    .im_i       (in_im),
    .frame_re_o (bank_re[1]),
    .frame_im_o (bank_im[1])
  );

  // The bank being read only changes when it is consumed, so the frame stays stable
  assign frame_re = rd_bank_q ? bank_re[1] : bank_re[0];
  assign frame_im = rd_bank_q ? bank_im[1] : bank_im[0];

  // Next-state for both sides; completing one bank and draining the other can coincide
  always_comb begin
    idx_d     = idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;

    if (consume) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      cnt_d             = cnt_q + 8'd1;
    end

    if (accept) begin
      if (last_slot) begin
        // A full count of beats always keeps the frame; a missing in_last is only flagged
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        idx_d             = '0;
        err_d             = ~in_last;
      end else if (in_last) begin
        // Early in_last drops the partial frame; the same bank is refilled from slot 0
        idx_d = '0;
        err_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Ready is registered: a freed bank reopens the write side one cycle later
    wr_state_d = full_d[wr_bank_d] ? W_STALL : W_FILL;
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk_100) begin
    if (reset_all) begin
      idx_q      <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      wr_state_q <= W_FILL;
    end else begin
      idx_q      <= idx_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      wr_state_q <= wr_state_d;
    end
  end

endmodule

// File: tb/tb_fft_input_framer.sv
// Testbench for fft_input_framer: directed sequences, slot table, random traffic.
module tb_fft_input_framer;

  localparam int DW = 16;
  localparam int NP = 32;
  localparam int FW = NP*DW;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, frame_ready;
  logic signed [DW-1:0] in_re, in_im;

  logic          in_ready_0, frame_valid_0, frame_err_0;
  logic [FW-1:0] frame_re_0, frame_im_0;
  logic [7:0]    frame_cnt_0;
  logic          in_ready_1, frame_valid_1, frame_err_1;
  logic [FW-1:0] frame_re_1, frame_im_1;
  logic [7:0]    frame_cnt_1;

  always #5 clk = ~clk;

  fft_input_framer #(.BIT_REVERSE(1)) dut (
    .clk_100(clk), .reset_all(rst), .in_valid(in_valid), .in_ready(in_ready_0),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .frame_valid(frame_valid_0),
    .frame_ready(frame_ready), .frame_re(frame_re_0), .frame_im(frame_im_0),
    .frame_err(frame_err_0), .frame_cnt(frame_cnt_0)
  );

  fft_input_framer #(.BIT_REVERSE(0)) dut_nat (
    .clk_100(clk), .reset_all(rst), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .frame_valid(frame_valid_1),
    .frame_ready(frame_ready), .frame_re(frame_re_1), .frame_im(frame_im_1),
    .frame_err(frame_err_1), .frame_cnt(frame_cnt_1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a queue of completed frames (oldest first) plus the one being built
  typedef struct {
    logic [FW-1:0] re, im, nre, nim;
  } frame_t;

  frame_t q[$];
  frame_t part;
  int     pcnt;
  int     exp_cnt;
  bit     exp_err;

  typedef struct {
    int slot;
    int exp_rev;
    int exp_nat;
  } slot_vec_t;

  slot_vec_t tbl[6];

  function automatic int rev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) r = r*2 + ((k >> b) & 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_frame(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      for (int s = 0; s < NP; s++) begin
        if (act[s*DW +: DW] !== exp[s*DW +: DW]) begin
          $display("FAIL %s: slot %0d got %h expected %h at %0t", nm, s,
                   act[s*DW +: DW], exp[s*DW +: DW], $time);
          break;
        end
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    part    = '{default: '0};
    pcnt    = 0;
    exp_cnt = 0;
    exp_err = 1'b0;
  endtask

  // One clock: check outputs against the model, drive inputs, step both across the edge
  task automatic tick(input bit r, input bit v, input int re, input int im,
                      input bit last, input bit fr);
    bit acc, cons;
    rst = r; in_valid = v; in_re = re[DW-1:0]; in_im = im[DW-1:0];
    in_last = last; frame_ready = fr;
    chk("in_ready",      in_ready_0,    q.size() < 2);
    chk("in_ready_nat",  in_ready_1,    q.size() < 2);
    chk("frame_valid",   frame_valid_0, q.size() > 0);
    chk("frame_valid_nat", frame_valid_1, q.size() > 0);
    chk("frame_err",     frame_err_0,   exp_err);
    chk("frame_err_nat", frame_err_1,   exp_err);
    chk("frame_cnt",     frame_cnt_0,   exp_cnt);
    chk("frame_cnt_nat", frame_cnt_1,   exp_cnt);
    if (q.size() > 0) begin
      chk_frame("frame_re",     frame_re_0, q[0].re);
      chk_frame("frame_im",     frame_im_0, q[0].im);
      chk_frame("frame_re_nat", frame_re_1, q[0].nre);
      chk_frame("frame_im_nat", frame_im_1, q[0].nim);
    end
    acc  = !r && v && (q.size() < 2);
    cons = !r && fr && (q.size() > 0);
    @(posedge clk);
    #1;
    if (r) model_reset();
    else begin
      exp_err = 1'b0;
      if (cons) begin
        void'(q.pop_front());
        exp_cnt = (exp_cnt + 1) % 256;
      end
      if (acc) begin
        part.re[rev5(pcnt)*DW +: DW]  = re[DW-1:0];
        part.im[rev5(pcnt)*DW +: DW]  = im[DW-1:0];
        part.nre[pcnt*DW +: DW]       = re[DW-1:0];
        part.nim[pcnt*DW +: DW]       = im[DW-1:0];
        if (pcnt == NP-1) begin
          q.push_back(part);
          pcnt    = 0;
          exp_err = !last;
        end else if (last) begin
          pcnt    = 0;
          exp_err = 1'b1;
        end else begin
          pcnt++;
        end
      end
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {frame_valid_1, frame_valid_0}, 2'b00);
    chk({tag, "_err"},   {frame_err_1, frame_err_0},     2'b00);
    chk({tag, "_cnt"},   {frame_cnt_1, frame_cnt_0},     16'd0);
    chk({tag, "_ready"}, {in_ready_1, in_ready_0},       2'b11);
    chk_frame({tag, "_re"},     frame_re_0, '0);
    chk_frame({tag, "_im"},     frame_im_0, '0);
    chk_frame({tag, "_re_nat"}, frame_re_1, '0);
  endtask

  task automatic send_frame(input bit fr);
    for (int k = 0; k < NP; k++)
      tick(0, 1, int'($urandom), int'($urandom), k == NP-1, fr);
  endtask

  initial begin
    int drops, hs, errs;
    logic [DW-1:0] e_re, e_im;

    tbl[0] = '{1, 16, 1};
    tbl[1] = '{31, 31, 31};
    tbl[2] = '{0, 0, 0};
    tbl[3] = '{2, 8, 2};
    tbl[4] = '{16, 1, 16};
    tbl[5] = '{5, 20, 5};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; frame_ready = 1'b0;
    in_re = '0; in_im = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_reset_state("reset");

    // Ramp frame, bit-reversed placement
    for (int k = 0; k < NP; k++) tick(0, 1, k, -k, k == NP-1, 0);
    chk("t1_valid", frame_valid_0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      e_re = 16'(tbl[i].exp_rev);
      e_im = 16'(-tbl[i].exp_rev);
      chk("t1_slot_re",  frame_re_0[tbl[i].slot*DW +: DW], e_re);
      chk("t1_slot_im",  frame_im_0[tbl[i].slot*DW +: DW], e_im);
      e_re = 16'(tbl[i].exp_nat);
      chk("t1_slot_nat", frame_re_1[tbl[i].slot*DW +: DW], e_re);
    end

    // Back-to-back streaming with a ready consumer
    tick(1, 0, 0, 0, 0, 0);
    drops = 0; hs = 0; errs = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NP; k++) begin
        if (!in_ready_0) drops++;
        if (frame_valid_0) hs++;
        if (frame_err_0) errs++;
        tick(0, 1, int'($urandom), int'($urandom), k == NP-1, 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (frame_valid_0) hs++;
      if (frame_err_0) errs++;
      tick(0, 0, 0, 0, 0, 1);
    end
    chk("t2_ready_drops", drops, 0);
    chk("t2_handshakes", hs, 3);
    chk("t2_errs", errs, 0);
    chk("t2_cnt", frame_cnt_0, 8'd3);

    // Both banks full, then a single consume
    tick(1, 0, 0, 0, 0, 0);
    send_frame(0);
    send_frame(0);
    chk("t3_stall", in_ready_0, 1'b0);
    for (int i = 0; i < 4; i++) tick(0, 1, int'($urandom), 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    chk("t3_ready_back", in_ready_0, 1'b1);
    chk("t3_cnt", frame_cnt_0, 8'd1);

    // Early in_last
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) tick(0, 1, 100 + k, k, k == 9, 0);
    chk("t4_err_pulse", frame_err_0, 1'b1);
    chk("t4_no_valid", frame_valid_0, 1'b0);
    tick(0, 0, 0, 0, 0, 0);
    chk("t4_err_clear", frame_err_0, 1'b0);
    send_frame(0);
    chk("t4_valid", frame_valid_0, 1'b1);
    tick(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a frame
    tick(1, 0, 0, 0, 0, 0);
    send_frame(1);
    for (int k = 0; k < 20; k++) tick(0, 1, int'($urandom), int'($urandom), 0, 0);
    tick(1, 1, 7, 7, 0, 1);
    chk_reset_state("t5_reset");
    tick(0, 0, 0, 0, 0, 0);
    chk("t5_no_valid", frame_valid_0, 1'b0);
    send_frame(0);
    chk("t5_valid", frame_valid_0, 1'b1);
    tick(0, 0, 0, 0, 0, 0);

    // 256 consumed frames wrap the counter
    tick(1, 0, 0, 0, 0, 0);
    for (int f = 0; f < 256; f++) send_frame(1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    chk("t6_cnt_wrap", frame_cnt_0, 8'd0);

    // Random traffic, occasional misaligned last and rare resets
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom % 700) == 0, ($urandom % 4) != 0, int'($urandom), int'($urandom),
           (pcnt == NP-1) ^ (($urandom % 40) == 0), ($urandom % 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
